// File: rtl/counter_pkg.sv
// counter_pkg: shared mode encoding and default width for the parameterised counter
package counter_pkg;
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing one step every PRESCALE enabled cycles
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] r_phase;
  assign step = en && (r_phase == LAST);
  // phase advances only on enabled cycles and restarts after each step or a clear
  always_ff @(posedge clk or posedge rst)
    if (rst) r_phase <= '0;
    else if (clr) r_phase <= '0;
    else if (en) r_phase <= step ? '0 : r_phase + 1'b1;
endmodule

// File: rtl/param_counter.sv
// param_counter: up/down counter over 0..max_val with prescaler, wrap/saturate and sticky overflow
module param_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf,
  output logic             tc
);
  logic             w_step;
  logic             w_sat;
  logic             w_wrap_nxt;
  logic [WIDTH:0]   w_cnt;
  logic [WIDTH:0]   w_max;
  logic [WIDTH:0]   w_ld;
  logic [WIDTH:0]   w_next;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;
  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (w_step)
  );
  assign w_sat = (mode == MODE_SAT);
  assign w_cnt = {1'b0, r_count};
  assign w_max = {1'b0, max_val};
  assign w_ld  = {1'b0, load_val};
  // next count and wrap event; the extra bit keeps count+1 from aliasing at the top of range
  always_comb begin
    w_next     = w_cnt;
    w_wrap_nxt = 1'b0;
    if (load) w_next = w_ld > w_max ? w_max : w_ld;
    else if (w_step && up) begin
      w_wrap_nxt = w_cnt >= w_max;
      w_next     = w_cnt < w_max ? w_cnt + 1'b1 : (w_sat ? w_max : '0);
    end else if (w_step) begin
      w_wrap_nxt = w_cnt == '0;
      w_next     = w_cnt == '0 ? (w_sat ? '0 : w_max) : (w_cnt > w_max ? w_max : w_cnt - 1'b1);
    end
  end
  // state registers; a new wrap beats a simultaneous clear of the sticky flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= WIDTH'(w_next);
      r_wrap  <= w_wrap_nxt;
      r_ovf   <= w_wrap_nxt | (r_ovf & ~clr_ovf);
    end
  assign count = r_count;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;
  assign tc    = up ? (r_count == max_val) : (r_count == '0);
endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: scoreboard bench for param_counter (PRESCALE 1 and 3 instances)
module tb_param_counter;
  typedef struct {
    int cnt;
    int wr;
    int ov;
    int tc;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b0, mode = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [3:0] load_val = '0, max_val = '0;
  logic [3:0] count;
  logic       wrap, ovf, tc;
  logic       en3 = 1'b0, load3 = 1'b0;
  logic [3:0] load_val3 = '0;
  logic [3:0] max_val3 = 4'd15;
  logic [3:0] count3;
  logic       wrap3, ovf3, tc3;
  exp_t       sb[$];
  int         sb3[$];
  int         n_chk = 0, n_pass = 0;
  int         m_cnt = 0, m_ovf = 0;
  always #5 clk = ~clk;
  param_counter #(.WIDTH(4), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .count(count), .wrap(wrap), .ovf(ovf), .tc(tc)
  );
  param_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .up(1'b1), .mode(1'b0), .load(load3),
    .load_val(load_val3), .max_val(max_val3), .clr_ovf(1'b0),
    .count(count3), .wrap(wrap3), .ovf(ovf3), .tc(tc3)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask
  task automatic cyc(input logic e, input logic u, input logic m, input logic l,
                     input int lv, input int mv, input logic c);
    exp_t x;
    int nc, nw;
    en = e; up = u; mode = m; load = l; load_val = 4'(lv); max_val = 4'(mv); clr_ovf = c;
    nw = 0;
    nc = m_cnt;
    if (l) nc = lv > mv ? mv : lv;
    else if (e && u) begin
      if (m_cnt < mv) nc = m_cnt + 1;
      else begin nc = m ? mv : 0; nw = 1; end
    end else if (e) begin
      if (m_cnt == 0) begin nc = m ? 0 : mv; nw = 1; end
      else nc = m_cnt > mv ? mv : m_cnt - 1;
    end
    m_cnt = nc;
    m_ovf = (nw == 1 || (m_ovf == 1 && !c)) ? 1 : 0;
    x.cnt = nc; x.wr = nw; x.ov = m_ovf; x.tc = (u ? nc == mv : nc == 0) ? 1 : 0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("count", int'(count), x.cnt);
    chk("wrap", int'(wrap), x.wr);
    chk("ovf", int'(ovf), x.ov);
    chk("tc", int'(tc), x.tc);
  endtask
  task automatic cyc3(input logic e, input logic l, input int lv, input int expc);
    en3 = e; load3 = l; load_val3 = 4'(lv);
    sb3.push_back(expc);
    @(posedge clk);
    #1;
    chk("count3", int'(count3), sb3.pop_front());
  endtask
  task automatic async_rst;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_ovf", int'(ovf), 0);
    chk("arst_wrap", int'(wrap), 0);
    chk("arst_count3", int'(count3), 0);
    #2 rst = 1'b0;
    m_cnt = 0;
    m_ovf = 0;
  endtask
  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_count3", int'(count3), 0);
    #7 rst = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0, 15, 0);
    cyc(0, 1, 0, 0, 0, 15, 0);
    cyc(0, 1, 1, 1, 0, 9, 1);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0, 0, 9, 0);
    cyc(0, 1, 0, 1, 12, 7, 0);
    cyc(1, 1, 0, 1, 3, 7, 0);
    cyc(0, 0, 0, 1, 0, 5, 1);
    cyc(1, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 5, 1);
    cyc(0, 0, 0, 1, 0, 5, 0);
    cyc(1, 0, 0, 0, 0, 5, 1);
    cyc(0, 1, 0, 1, 3, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 15, 15, 0);
    cyc(1, 1, 0, 0, 0, 15, 0);
    cyc(0, 1, 0, 1, 6, 15, 0);
    async_rst();
    cyc(0, 1, 0, 0, 0, 15, 0);
    cyc3(1, 0, 0, 0);
    cyc3(1, 0, 0, 0);
    cyc3(0, 0, 0, 0);
    cyc3(1, 0, 0, 1);
    cyc3(1, 0, 0, 1);
    cyc3(1, 1, 0, 0);
    cyc3(1, 0, 0, 0);
    cyc3(1, 0, 0, 0);
    cyc3(1, 0, 0, 1);
    cyc3(1, 0, 0, 1);
    cyc3(1, 0, 0, 1);
    async_rst();
    cyc3(1, 0, 0, 0);
    cyc3(1, 0, 0, 0);
    cyc3(1, 0, 0, 1);
    for (int i = 0; i < 150; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 7) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4; bit width of count, load_val and max_val (legal range 2..32).
REQ-002 SHALL have parameter PRESCALE, default 1; number of enabled cycles per count step (legal range 1..256).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port en  input  1  count enable; feeds the prescaler.
REQ-006 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 SHALL have port mode  input  1  overflow mode; 0 = wrap, 1 = saturate.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value applied on load.
REQ-010 SHALL have port max_val  input  WIDTH  terminal value; the count range is 0..max_val.
REQ-011 SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-012 SHALL have port count  output  WIDTH  registered count value.
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse on a wrap or saturation-limited step.
REQ-014 SHALL have port ovf  output  1  sticky flag, set by any wrap pulse.
REQ-015 SHALL have port tc  output  1  combinational; high when count == max_val (up=1) or count == 0 (up=0).

Function
REQ-016 Prescaler: step SHALL assert on every PRESCALE-th cycle in which en=1; phase holds while en=0; PRESCALE=1 gives step = en.
REQ-017 Priority per cycle SHALL be load > step > hold.
REQ-018 On load, count SHALL take min(load_val, max_val), the prescaler phase SHALL clear to 0, and wrap SHALL be 0.
REQ-019 On step with up=1 and count < max_val: count+1.
REQ-020 On step with up=1 and count >= max_val: wrap mode gives 0; saturate mode gives max_val (clamps if above); wrap=1 in both cases.
REQ-021 On step with up=0 and count > 0: count-1; if count > max_val, it SHALL clamp to max_val instead.
REQ-022 On step with up=0 and count == 0: wrap mode gives max_val; saturate mode holds 0; wrap=1 in both cases.
REQ-023 wrap SHALL be high for exactly the cycle after the step that caused it and low otherwise.
REQ-024 ovf SHALL set when wrap is set; clr_ovf SHALL clear it; a simultaneous set and clear SHALL leave ovf=1.
REQ-025 max_val=0 SHALL hold count at 0, with every step producing wrap=1.
REQ-026 A change of max_val SHALL take effect on the next step with no stall; up, mode and max_val SHALL be sampled only on step or load cycles.
REQ-027 All arithmetic SHALL be performed at WIDTH+1 bits internally so that count+1 never aliases at max_val = 2^WIDTH-1.

Reset
REQ-028 rst=1 SHALL asynchronously force count=0, wrap=0, ovf=0 and prescaler phase=0.
REQ-029 Reset asserted mid-count SHALL discard any pending step; the first step after release SHALL occur PRESCALE enabled cycles later.

Structure
REQ-030 Package counter_pkg SHALL hold the mode encoding (MODE_WRAP=0, MODE_SAT=1) and the constant DEFAULT_WIDTH=4.
REQ-031 The prescaler SHALL be a sub-module tick_gen (parameter PRESCALE; ports clk, rst, en, clr, step).
REQ-032 With WIDTH=4, PRESCALE=1, mode=wrap, max_val=15 and up=1, the block SHALL be drop-in equivalent to the existing 4-bit free-running counter.

Verification
REQ-033 Test: WIDTH=4, PRESCALE=1, en=1, up=1, max_val=15, wrap mode, rst released at 10 ns -> count 0,1,...,15,0; wrap high one cycle after the 15->0 step; ovf=1 thereafter.
REQ-034 Test: saturate mode, max_val=9, up=1 for 12 steps -> count stops at 9; wrap pulses on each of steps 10-12; count never exceeds 9.
REQ-035 Test: PRESCALE=3, en toggled 1,1,0,1 -> a single step after the third enabled cycle; count 0->1.
REQ-036 Test: load=1 with load_val=12 and max_val=7 -> count=7; load and step in the same cycle -> load wins and the prescaler phase clears.
REQ-037 Test: up=0 from count=0, wrap mode, max_val=5 -> count=5 with wrap=1; clr_ovf and a new wrap in the same cycle -> ovf stays 1.
REQ-038 Test: rst pulsed asynchronously mid-cycle at count=6 -> count=0, ovf=0 immediately, without waiting for a clock edge.
